// File: rtl/wb_bram_pkg.sv
// Shared types and helpers for the Wishbone-to-block-RAM initiator.
// The state enum carries all four states even when WB_BRAM_RMW_EN is not
// defined, so the encoding stays the same in both builds.
package wb_bram_pkg;

    // Upper bound on the byte-select width handled by all_ones_sel()
    localparam int MAX_SEL_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD     = 2'd1,
        RMW_RD = 2'd2,
        RMW_WR = 2'd3
    } state_t;

    // Number of byte lanes in a data word
    function automatic int sel_width_of(input int data_width);
        return data_width / 8;
    endfunction

    // Byte-select value with every lane set (a full-word write)
    function automatic logic [MAX_SEL_WIDTH-1:0] all_ones_sel(input int sel_width);
        logic [MAX_SEL_WIDTH-1:0] mask;
        mask = '0;
        for (int k = 0; k < MAX_SEL_WIDTH; k++) begin
            if (k < sel_width) begin
                mask[k] = 1'b1;
            end
        end
        return mask;
    endfunction

endpackage

// File: rtl/wb_bram_byte_merge.sv
// Per-byte merge of old RAM contents with new write data under a byte select.
// Used only by the read-modify-write path of wb_bram_initiator.
module wb_bram_byte_merge
    import wb_bram_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int SEL_WIDTH  = sel_width_of(DATA_WIDTH)
) (
    input  logic [DATA_WIDTH-1:0] old_data,
    input  logic [DATA_WIDTH-1:0] new_data,
    input  logic [SEL_WIDTH-1:0]  sel,
    output logic [DATA_WIDTH-1:0] merged_data
);

    // Take each byte from the new word where its select bit is set, else keep the old byte
    always_comb begin
        merged_data = old_data;
        for (int k = 0; k < SEL_WIDTH; k++) begin
            if (sel[k]) begin
                merged_data[8*k +: 8] = new_data[8*k +: 8];
            end
        end
    end

endmodule

// File: rtl/wb_bram_initiator.sv
// Wishbone pipelined slave that drives one port of a true dual-port block RAM.
// Full writes complete in one cycle and reads take two. With WB_BRAM_RMW_EN
// defined, partial-byte writes run as read-modify-write. Without it, byte
// selects are ignored and every write stores the full word.
// All RAM-side outputs and the ack are registered.
module wb_bram_initiator
    import wb_bram_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 10,
    localparam int SEL_WIDTH  = sel_width_of(DATA_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_wb_cyc,
    input  logic                  i_wb_stb,
    input  logic                  i_wb_we,
    input  logic [ADDR_WIDTH-1:0] i_wb_addr,
    input  logic [DATA_WIDTH-1:0] i_wb_data,
    input  logic [SEL_WIDTH-1:0]  i_wb_sel,
    output logic                  o_wb_stall,
    output logic                  o_wb_ack,
    output logic [DATA_WIDTH-1:0] o_wb_data,
    output logic                  o_bram_en,
    output logic                  o_bram_we,
    output logic [ADDR_WIDTH-1:0] o_bram_addr,
    output logic [DATA_WIDTH-1:0] o_bram_din,
    input  logic [DATA_WIDTH-1:0] i_bram_dout
);

    state_t                state;
    state_t                next_state;
    logic                  accept;
    logic                  bram_en_d;
    logic                  bram_we_d;
    logic [ADDR_WIDTH-1:0] bram_addr_d;
    logic [DATA_WIDTH-1:0] bram_din_d;
    logic                  wb_ack_d;
    logic                  rd_ack_d;
    logic                  rd_ack_q;

    // A request is taken only in IDLE, which is also the only non-stalled state
    assign accept     = i_wb_cyc && i_wb_stb && (state == IDLE);
    assign o_wb_stall = (state != IDLE);

    // RAM read data is passed straight through, but only during a read ack
    assign o_wb_data  = rd_ack_q ? i_bram_dout : '0;

`ifdef WB_BRAM_RMW_EN
    localparam logic [SEL_WIDTH-1:0] SEL_ALL = SEL_WIDTH'(all_ones_sel(SEL_WIDTH));

    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [SEL_WIDTH-1:0]  sel_q;
    logic [DATA_WIDTH-1:0] merged_data;
    logic                  sel_full;
    logic                  sel_zero;

    assign sel_full = (i_wb_sel == SEL_ALL);
    assign sel_zero = (i_wb_sel == '0);

    // Hold the write data and selects of the accepted request for the merge
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            wr_data_q <= '0;
            sel_q     <= '0;
        end else if (accept) begin
            wr_data_q <= i_wb_data;
            sel_q     <= i_wb_sel;
        end
    end

    wb_bram_byte_merge #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_byte_merge (
        .old_data    (i_bram_dout),
        .new_data    (wr_data_q),
        .sel         (sel_q),
        .merged_data (merged_data)
    );
`else
    logic unused_sel;
    assign unused_sel = ^i_wb_sel;
`endif

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a dropped cycle returns every busy state to IDLE
    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: begin
                if (accept && !i_wb_we) begin
                    next_state = RD;
                end
`ifdef WB_BRAM_RMW_EN
                else if (accept && !sel_full && !sel_zero) begin
                    next_state = RMW_RD;
                end
`endif
            end
            RD: begin
                next_state = IDLE;
            end
`ifdef WB_BRAM_RMW_EN
            RMW_RD: begin
                next_state = i_wb_cyc ? RMW_WR : IDLE;
            end
            RMW_WR: begin
                next_state = IDLE;
            end
`endif
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Values the registered outputs take at the next edge; address and write data hold otherwise
    always_comb begin
        bram_en_d   = 1'b0;
        bram_we_d   = 1'b0;
        bram_addr_d = o_bram_addr;
        bram_din_d  = o_bram_din;
        wb_ack_d    = 1'b0;
        rd_ack_d    = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    bram_addr_d = i_wb_addr;
                    if (!i_wb_we) begin
                        bram_en_d = 1'b1;
                    end else begin
`ifdef WB_BRAM_RMW_EN
                        if (sel_full) begin
                            bram_en_d  = 1'b1;
                            bram_we_d  = 1'b1;
                            bram_din_d = i_wb_data;
                            wb_ack_d   = 1'b1;
                        end else if (sel_zero) begin
                            wb_ack_d   = 1'b1;
                        end else begin
                            bram_en_d  = 1'b1;
                        end
`else
                        bram_en_d  = 1'b1;
                        bram_we_d  = 1'b1;
                        bram_din_d = i_wb_data;
                        wb_ack_d   = 1'b1;
`endif
                    end
                end
            end
            RD: begin
                wb_ack_d = i_wb_cyc;
                rd_ack_d = i_wb_cyc;
            end
`ifdef WB_BRAM_RMW_EN
            RMW_WR: begin
                if (i_wb_cyc) begin
                    bram_en_d  = 1'b1;
                    bram_we_d  = 1'b1;
                    bram_din_d = merged_data;
                    wb_ack_d   = 1'b1;
                end
            end
`endif
            default: begin
            end
        endcase
    end

    // Output registers
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_bram_en   <= 1'b0;
            o_bram_we   <= 1'b0;
            o_bram_addr <= '0;
            o_bram_din  <= '0;
            o_wb_ack    <= 1'b0;
            rd_ack_q    <= 1'b0;
        end else begin
            o_bram_en   <= bram_en_d;
            o_bram_we   <= bram_we_d;
            o_bram_addr <= bram_addr_d;
            o_bram_din  <= bram_din_d;
            o_wb_ack    <= wb_ack_d;
            rd_ack_q    <= rd_ack_d;
        end
    end

endmodule

// File: tb/tb_wb_bram_initiator.sv
// Directed testbench for wb_bram_initiator with a behavioural RAM on the port.
// Covers the RMW path when WB_BRAM_RMW_EN is defined and the full-word-only
// behaviour when it is not.
module tb_wb_bram_initiator;

    logic        i_clk = 1'b0;
    logic        i_reset_n;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic        i_wb_we;
    logic [9:0]  i_wb_addr;
    logic [31:0] i_wb_data;
    logic [3:0]  i_wb_sel;
    logic        o_wb_stall;
    logic        o_wb_ack;
    logic [31:0] o_wb_data;
    logic        o_bram_en;
    logic        o_bram_we;
    logic [9:0]  o_bram_addr;
    logic [31:0] o_bram_din;
    logic [31:0] i_bram_dout;

    logic [31:0] mem [0:1023];

    int passCount  = 0;
    int checkCount = 0;

    wb_bram_initiator #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (10)
    ) dut (
        .i_clk       (i_clk),
        .i_reset_n   (i_reset_n),
        .i_wb_cyc    (i_wb_cyc),
        .i_wb_stb    (i_wb_stb),
        .i_wb_we     (i_wb_we),
        .i_wb_addr   (i_wb_addr),
        .i_wb_data   (i_wb_data),
        .i_wb_sel    (i_wb_sel),
        .o_wb_stall  (o_wb_stall),
        .o_wb_ack    (o_wb_ack),
        .o_wb_data   (o_wb_data),
        .o_bram_en   (o_bram_en),
        .o_bram_we   (o_bram_we),
        .o_bram_addr (o_bram_addr),
        .o_bram_din  (o_bram_din),
        .i_bram_dout (i_bram_dout)
    );

    always #5 i_clk = ~i_clk;

    // Behavioural RAM port: read-first, one-cycle registered read
    always @(posedge i_clk) begin
        if (o_bram_en) begin
            if (o_bram_we) begin
                mem[o_bram_addr] <= o_bram_din;
            end
            i_bram_dout <= mem[o_bram_addr];
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic cyc, input logic stb, input logic we,
                                 input logic [9:0] addr, input logic [31:0] data,
                                 input logic [3:0] sel);
        i_wb_cyc  = cyc;
        i_wb_stb  = stb;
        i_wb_we   = we;
        i_wb_addr = addr;
        i_wb_data = data;
        i_wb_sel  = sel;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic doFullWrite(input string tag, input logic [9:0] addr, input logic [31:0] data);
        applyStimulus(1'b1, 1'b1, 1'b1, addr, data, 4'hF);
        tick();
        checkOutput({tag, "_ack"}, 32'(o_wb_ack), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
    endtask

    task automatic doRead(input string tag, input logic [9:0] addr, input logic [31:0] expected);
        applyStimulus(1'b1, 1'b1, 1'b0, addr, 32'h0, 4'h0);
        tick();
        checkOutput({tag, "_en"}, 32'(o_bram_en & ~o_bram_we), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, addr, 32'h0, 4'h0);
        tick();
        checkOutput({tag, "_ack"}, 32'(o_wb_ack), 32'd1);
        checkOutput({tag, "_data"}, o_wb_data, expected);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
    endtask

    initial begin
        // Reset state
        i_reset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
        tick();
        tick();
        checkOutput("rst_stall", 32'(o_wb_stall), 32'd0);
        checkOutput("rst_ack",   32'(o_wb_ack),   32'd0);
        checkOutput("rst_en",    32'(o_bram_en),  32'd0);
        checkOutput("rst_addr",  32'(o_bram_addr), 32'd0);
        checkOutput("rst_din",   o_bram_din,      32'd0);
        checkOutput("rst_data",  o_wb_data,       32'd0);
        i_reset_n = 1'b1;
        tick();

        // Full write to 0x005, then read it back
        applyStimulus(1'b1, 1'b1, 1'b1, 10'h005, 32'hDEADBEEF, 4'hF);
        checkOutput("fw_stall_T", 32'(o_wb_stall), 32'd0);
        tick();
        checkOutput("fw_en",   32'(o_bram_en),   32'd1);
        checkOutput("fw_we",   32'(o_bram_we),   32'd1);
        checkOutput("fw_addr", 32'(o_bram_addr), 32'h005);
        checkOutput("fw_din",  o_bram_din,       32'hDEADBEEF);
        checkOutput("fw_ack",  32'(o_wb_ack),    32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
        tick();
        checkOutput("fw_ack_T2", 32'(o_wb_ack),  32'd0);
        checkOutput("fw_en_T2",  32'(o_bram_en), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 10'h005, 32'h0, 4'h0);
        tick();
        checkOutput("rd_stall_T1", 32'(o_wb_stall), 32'd1);
        checkOutput("rd_ack_T1",   32'(o_wb_ack),   32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
        tick();
        checkOutput("rd_ack_T2",   32'(o_wb_ack),   32'd1);
        checkOutput("rd_data_T2",  o_wb_data,       32'hDEADBEEF);
        checkOutput("rd_stall_T2", 32'(o_wb_stall), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
        tick();
        checkOutput("rd_ack_T3",  32'(o_wb_ack), 32'd0);
        checkOutput("rd_data_T3", o_wb_data,     32'd0);

`ifdef WB_BRAM_RMW_EN
        // Partial write: RAM[0x010]=0x11223344, write 0xAABBCCDD sel 0x5 -> 0x11BB33DD
        doFullWrite("pre10", 10'h010, 32'h11223344);
        applyStimulus(1'b1, 1'b1, 1'b1, 10'h010, 32'hAABBCCDD, 4'h5);
        tick();
        checkOutput("pw_en_T1",    32'(o_bram_en),  32'd1);
        checkOutput("pw_we_T1",    32'(o_bram_we),  32'd0);
        checkOutput("pw_stall_T1", 32'(o_wb_stall), 32'd1);
        checkOutput("pw_ack_T1",   32'(o_wb_ack),   32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1, 10'h3FF, 32'h99999999, 4'hF);
        tick();
        checkOutput("pw_en_T2",    32'(o_bram_en),  32'd0);
        checkOutput("pw_stall_T2", 32'(o_wb_stall), 32'd1);
        checkOutput("pw_ack_T2",   32'(o_wb_ack),   32'd0);
        tick();
        checkOutput("pw_en_T3",   32'(o_bram_en & o_bram_we), 32'd1);
        checkOutput("pw_addr_T3", 32'(o_bram_addr), 32'h010);
        checkOutput("pw_din_T3",  o_bram_din,       32'h11BB33DD);
        checkOutput("pw_ack_T3",  32'(o_wb_ack),    32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
        tick();
        checkOutput("pw_ack_T4", 32'(o_wb_ack), 32'd0);
        doRead("pw_rb", 10'h010, 32'h11BB33DD);

        // Zero-sel write: ack at T+1 without touching the RAM
        applyStimulus(1'b1, 1'b1, 1'b1, 10'h020, 32'h12345678, 4'h0);
        tick();
        checkOutput("zs_ack", 32'(o_wb_ack),  32'd1);
        checkOutput("zs_en",  32'(o_bram_en), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
`else
        // Macro off: byte selects ignored, full word written at T+1
        applyStimulus(1'b1, 1'b1, 1'b1, 10'h020, 32'hAABBCCDD, 4'h1);
        tick();
        checkOutput("mo_en",    32'(o_bram_en & o_bram_we), 32'd1);
        checkOutput("mo_din",   o_bram_din,       32'hAABBCCDD);
        checkOutput("mo_ack",   32'(o_wb_ack),    32'd1);
        checkOutput("mo_stall", 32'(o_wb_stall),  32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
        tick();
        checkOutput("mo_en_T2", 32'(o_bram_en), 32'd0);
        doRead("mo_rb", 10'h020, 32'hAABBCCDD);
`endif
        tick();

        // Back-to-back full writes to 0x001..0x004
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 10'(i), 32'h10000000 + 32'(i), 4'hF);
            tick();
            checkOutput("b2b_ack",   32'(o_wb_ack),    32'd1);
            checkOutput("b2b_addr",  32'(o_bram_addr), 32'(i));
            checkOutput("b2b_din",   o_bram_din,       32'h10000000 + 32'(i));
            checkOutput("b2b_stall", 32'(o_wb_stall),  32'd0);
        end

        // Read followed by read: second accepted at T+2
        applyStimulus(1'b1, 1'b1, 1'b0, 10'h001, 32'h0, 4'h0);
        tick();
        checkOutput("rr_stall_T1", 32'(o_wb_stall), 32'd1);
        applyStimulus(1'b1, 1'b1, 1'b0, 10'h002, 32'h0, 4'h0);
        tick();
        checkOutput("rr_ack1",     32'(o_wb_ack),   32'd1);
        checkOutput("rr_data1",    o_wb_data,       32'h10000001);
        checkOutput("rr_stall_T2", 32'(o_wb_stall), 32'd0);
        tick();
        checkOutput("rr_en2",   32'(o_bram_en),   32'd1);
        checkOutput("rr_addr2", 32'(o_bram_addr), 32'h002);
        checkOutput("rr_ack_T3", 32'(o_wb_ack),   32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
        tick();
        checkOutput("rr_ack2",  32'(o_wb_ack), 32'd1);
        checkOutput("rr_data2", o_wb_data,     32'h10000002);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
        tick();

`ifdef WB_BRAM_RMW_EN
        // Abort: partial write, cyc dropped at T+1 -> no ack, no write
        doFullWrite("pre30", 10'h030, 32'hCAFEF00D);
        applyStimulus(1'b1, 1'b1, 1'b1, 10'h030, 32'h12345678, 4'h3);
        tick();
        checkOutput("ab_en_T1", 32'(o_bram_en), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
        tick();
        checkOutput("ab_stall_T2", 32'(o_wb_stall), 32'd0);
        checkOutput("ab_ack_T2",   32'(o_wb_ack),   32'd0);
        tick();
        checkOutput("ab_we_T3",  32'(o_bram_we), 32'd0);
        checkOutput("ab_ack_T3", 32'(o_wb_ack),  32'd0);
        doRead("ab_rb", 10'h030, 32'hCAFEF00D);
        tick();

        // Reset asserted mid-RMW at T+2
        applyStimulus(1'b1, 1'b1, 1'b1, 10'h010, 32'h55667788, 4'h2);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 10'h010, 32'h55667788, 4'h2);
        tick();
        checkOutput("mr_stall_pre", 32'(o_wb_stall), 32'd1);
`else
        // Abort: read accepted, cyc dropped at T+1 -> no ack
        applyStimulus(1'b1, 1'b1, 1'b0, 10'h005, 32'h0, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
        tick();
        checkOutput("ab_ack_T2",   32'(o_wb_ack),   32'd0);
        checkOutput("ab_stall_T2", 32'(o_wb_stall), 32'd0);
        tick();

        // Reset asserted while a read is outstanding
        applyStimulus(1'b1, 1'b1, 1'b0, 10'h005, 32'h0, 4'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 10'h005, 32'h0, 4'h0);
        checkOutput("mr_stall_pre", 32'(o_wb_stall), 32'd1);
`endif
        i_reset_n = 1'b0;
        #1;
        checkOutput("mr_stall", 32'(o_wb_stall),  32'd0);
        checkOutput("mr_ack",   32'(o_wb_ack),    32'd0);
        checkOutput("mr_en",    32'(o_bram_en),   32'd0);
        checkOutput("mr_we",    32'(o_bram_we),   32'd0);
        checkOutput("mr_addr",  32'(o_bram_addr), 32'd0);
        checkOutput("mr_din",   o_bram_din,       32'd0);
        checkOutput("mr_data",  o_wb_data,        32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
        tick();
        i_reset_n = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1, 10'h007, 32'h0BADF00D, 4'hF);
        checkOutput("mr_post_stall", 32'(o_wb_stall), 32'd0);
        tick();
        checkOutput("mr_post_ack",  32'(o_wb_ack),    32'd1);
        checkOutput("mr_post_addr", 32'(o_bram_addr), 32'h007);
        applyStimulus(1'b0, 1'b0, 1'b0, 10'h000, 32'h0, 4'h0);
        tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
